// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction prefetch stage. Issues sequential word-aligned fetches to the
//   memory arbiter, buffers returned words with their PCs in a DEPTH-entry
//   FIFO and hands them to decode over a valid/ready handshake. A redirect
//   flushes the queue, restarts fetch at the new PC and drops the response of
//   any request issued before it.
//
//   Optional feature (macro PREFETCH_BYPASS_EN): when the FIFO is empty, a live
//   response is presented to decode combinationally in its arrival cycle, and
//   is only written into the FIFO if decode does not take it that cycle.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   redirect_i        flush and restart fetch at redirect_pc_i
//   redirect_pc_i     new fetch PC (low two bits ignored)
//   mem_req_o         fetch request to the arbiter
//   mem_addr_o        fetch address (word aligned)
//   mem_gnt_i         arbiter accepted the request this cycle
//   mem_rvalid_i      read data valid, one cycle after acceptance
//   mem_rdata_i       read data
//   instr_valid_o     head entry valid
//   instr_o           head instruction word (0 when empty)
//   instr_pc_o        PC of the head instruction (0 when empty)
//   instr_ready_i     decode consumes the head this cycle

module prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // count spans 0..DEPTH
    localparam int UW = CW + 1;   // count + inflight without overflow

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          inflight_vld;
    logic [31:0]   inflight_pc;
    logic          acc_q;         // a request was accepted last cycle

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [UW-1:0] used;
    logic          accept;
    logic          resp;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Credit: every outstanding request already owns a FIFO slot, so a
    // response can always be written.
    assign used       = UW'(count) + UW'(inflight_vld);
    assign mem_req_o  = !reset && !redirect_i && (used < UW'(DEPTH));
    assign mem_addr_o = fetch_pc;
    assign accept     = mem_req_o && mem_gnt_i;

    // A response is live only if its request has not been made stale by a
    // redirect or reset.
    assign resp       = mem_rvalid_i && inflight_vld && !reset;
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && instr_ready_i;

`ifdef PREFETCH_BYPASS_EN
    logic byp;
    assign byp           = fifo_empty && resp;
    assign instr_valid_o = !fifo_empty || byp;
    assign instr_o       = !fifo_empty ? data_q[rd_ptr] : (byp ? mem_rdata_i : 32'h0);
    assign instr_pc_o    = !fifo_empty ? pc_q[rd_ptr]   : (byp ? inflight_pc : 32'h0);
    // A bypassed word taken by decode never enters the FIFO.
    assign push          = resp && !redirect_i && !(byp && instr_ready_i);
`else
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = !fifo_empty ? data_q[rd_ptr] : 32'h0;
    assign instr_pc_o    = !fifo_empty ? pc_q[rd_ptr]   : 32'h0;
    assign push          = resp && !redirect_i;
`endif

    // Storage has no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= mem_rdata_i;
            pc_q[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            inflight_vld <= 1'b0;
            inflight_pc  <= '0;
            acc_q        <= 1'b0;
        end else begin
            acc_q <= accept;
            if (redirect_i) begin
                // No request is issued this cycle, so clearing the valid bit
                // drops the response of anything issued before the redirect.
                fetch_pc     <= redirect_pc_i & ~32'h3;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                inflight_vld <= 1'b0;
            end else begin
                if (accept) begin
                    fetch_pc     <= fetch_pc + 32'd4;
                    inflight_vld <= 1'b1;
                    inflight_pc  <= fetch_pc;
                end else if (mem_rvalid_i) begin
                    inflight_vld <= 1'b0;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Read data must only follow an accepted request.
    rvalid_has_request: assert property (
        @(posedge clk) disable iff (reset) mem_rvalid_i |-> acc_q
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: reset values, streaming latency,
// backpressure credit limit, redirects (including address wrap), a random
// grant/ready soak with an in-order PC scoreboard, and reset mid-operation.
// Memory returns f(addr) = addr ^ 32'hDEAD_BEEF one cycle after each grant.

module tb_prefetch_queue;

    localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          ngrants = 0;
    int          npops = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_end;

    prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
        .instr_ready_i(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory: data one cycle after acceptance.
    always @(posedge clk) begin
        rvalid <= mem_req && gnt;
        rdata  <= f(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, sample after settling, and
    // check any pop against the in-order scoreboard.
    task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        gnt = g; ready = r; redirect = rd; redirect_pc = rpc;
        #1;
        if (mem_req && gnt) ngrants++;
        if (rd) begin
            exp_pc = rpc & ~32'h3;
        end else if (valid && ready) begin
            chk("pop_pc", ipc, exp_pc);
            chk("pop_data", instr, f(exp_pc));
            exp_pc = exp_pc + 32'd4;
            npops++;
        end
    endtask

    task automatic do_reset(input logic g, input logic r);
        reset = 1'b1; gnt = 1'b0; ready = 1'b0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", ipc, 32'h0);
        reset = 1'b0; gnt = g; ready = r;
        exp_pc = 32'h0; ngrants = 0; npops = 0;
        #1;
        chk("rel_req", mem_req, 1);
        if (mem_req && gnt) ngrants++;
    endtask

    initial begin
        // Streaming: one address per cycle, data LAT cycles behind.
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("str_addr", mem_addr, 32'(4 * k));
            chk("str_lat", valid, (k >= LAT) ? 32'd1 : 32'd0);
        end
        chk("str_npops", npops, 9 - LAT);

        // Backpressure: exactly DEPTH grants, head held at PC 0.
        do_reset(1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp_grants", ngrants, DEPTH);
        chk("bp_req", mem_req, 0);
        chk("bp_valid", valid, 1);
        chk("bp_head", ipc, 32'h0);
        chk("bp_count", 32'(dut.count), DEPTH);
        npops = 0;
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bp_drain", npops, 10);

        // Redirect with a request in flight; low bits dropped.
        step(1'b1, 1'b1, 1'b1, 32'h0000_1002);
        chk("rd_req", mem_req, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rd_addr", mem_addr, 32'h0000_1000);
        chk("rd_valid", valid, 0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rd_end", exp_pc, 32'h0000_1000 + 32'(4 * (7 - LAT)));

        // Redirect near the top of the address space: PCs wrap to 0.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wr_addr", mem_addr, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        exp_end = 32'hFFFF_FFF8 + 32'(4 * (7 - LAT));
        chk("wr_end", exp_pc, exp_end);

        // Random grant/ready soak; scoreboard catches skips and duplicates.
        npops = 0;
        repeat (1000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
            chk("cnt_max", 32'(dut.count <= DEPTH), 1);
        end
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("soak_empty", valid, 0);
        chk("soak_all", mem_addr, exp_pc);
        chk("soak_some", 32'(npops > 100), 1);

        // Reset with 3 entries queued and one request in flight.
        do_reset(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("mr_count", 32'(dut.count), 3);
        chk("mr_head", ipc, 32'h0);
        reset = 1'b1;
        #1;
        chk("mr_req", mem_req, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; ready = 1'b1;
        #1;
        chk("mr_valid", valid, 0);
        chk("mr_addr", mem_addr, 32'h0);
        exp_pc = 32'h0;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mr_end", exp_pc, 32'(4 * (7 - LAT)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
